// File: rtl/fft_pkg.sv
// Shared FFT definitions: SDF controller state encoding and the
// default sample width, half-block depth and lane count.
package fft_pkg;

  localparam int FFT_WIDTH = 10;
  localparam int FFT_DEPTH = 4;
  localparam int FFT_LANES = 16;

  typedef enum logic {
    FILL = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/bfly2.sv
// Radix-2 butterfly, LANES complex lanes, full precision.
// Ports: a_*/b_* WIDTH-bit operands; s_* = a+b, d_* = a-b (WIDTH+1 bits).
module bfly2 #(
  parameter int WIDTH = 10,
  parameter int LANES = 16
) (
  input  logic [LANES-1:0][WIDTH-1:0] a_re,
  input  logic [LANES-1:0][WIDTH-1:0] a_im,
  input  logic [LANES-1:0][WIDTH-1:0] b_re,
  input  logic [LANES-1:0][WIDTH-1:0] b_im,
  output logic [LANES-1:0][WIDTH:0]   s_re,
  output logic [LANES-1:0][WIDTH:0]   s_im,
  output logic [LANES-1:0][WIDTH:0]   d_re,
  output logic [LANES-1:0][WIDTH:0]   d_im
);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      s_re[l] = {a_re[l][WIDTH-1], a_re[l]}
              + {b_re[l][WIDTH-1], b_re[l]};
      s_im[l] = {a_im[l][WIDTH-1], a_im[l]}
              + {b_im[l][WIDTH-1], b_im[l]};
      d_re[l] = {a_re[l][WIDTH-1], a_re[l]}
              - {b_re[l][WIDTH-1], b_re[l]};
      d_im[l] = {a_im[l][WIDTH-1], a_im[l]}
              - {b_im[l][WIDTH-1], b_im[l]};
    end
  end

endmodule

// File: rtl/bf_sdf_ctrl.sv
// Single-delay-feedback radix-2 stage: buffers the first half-block,
// emits sums during the second half, then drains the differences.
// Ports: clk/rstn/clr control; in_valid/in_re/in_im input beat;
// out_valid/out_re/out_im/out_half/out_idx output beat; block_done, busy.
module bf_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = FFT_DEPTH,
  parameter int LANES = FFT_LANES,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [LANES-1:0][WIDTH-1:0] in_re,
  input  logic [LANES-1:0][WIDTH-1:0] in_im,
  output logic                       out_valid,
  output logic [LANES-1:0][WIDTH:0]  out_re,
  output logic [LANES-1:0][WIDTH:0]  out_im,
  output logic                       out_half,
  output logic [PW-1:0]              out_idx,
  output logic                       block_done,
  output logic                       busy
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  state_t          st, st_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic            drn, drn_n;
  logic [PW-1:0]   dcnt, dcnt_n;
  logic            acc;
  logic            busy_n;

  logic [LANES-1:0][WIDTH:0]   mem_re [DEPTH];
  logic [LANES-1:0][WIDTH:0]   mem_im [DEPTH];
  logic [LANES-1:0][WIDTH:0]   ext_re, ext_im;
  logic [LANES-1:0][WIDTH-1:0] a_re, a_im;
  logic [LANES-1:0][WIDTH:0]   sum_re, sum_im;
  logic [LANES-1:0][WIDTH:0]   dif_re, dif_im;

  // clr drops the beat presented in the same cycle
  assign acc = in_valid && !clr;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      ext_re[l] = {in_re[l][WIDTH-1], in_re[l]};
      ext_im[l] = {in_im[l][WIDTH-1], in_im[l]};
      a_re[l]   = mem_re[ptr][l][WIDTH-1:0];
      a_im[l]   = mem_im[ptr][l][WIDTH-1:0];
    end
  end

  bfly2 #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_bfly (
    .a_re (a_re),
    .a_im (a_im),
    .b_re (in_re),
    .b_im (in_im),
    .s_re (sum_re),
    .s_im (sum_im),
    .d_re (dif_re),
    .d_im (dif_im)
  );

  always_comb begin
    st_n   = st;
    ptr_n  = ptr;
    drn_n  = drn;
    dcnt_n = dcnt;
    if (drn) begin
      if (dcnt == LAST) drn_n = 1'b0;
      else dcnt_n = dcnt + PW'(1);
    end
    if (acc) begin
      ptr_n = ptr + PW'(1);
      if (ptr == LAST) begin
        st_n = (st == FILL) ? CALC : FILL;
        // last difference lands this edge; drain reads from next cycle
        if (st == CALC) begin
          drn_n  = 1'b1;
          dcnt_n = '0;
        end
      end
    end
    if (clr) begin
      st_n   = FILL;
      ptr_n  = '0;
      drn_n  = 1'b0;
      dcnt_n = '0;
    end
    // keep busy through the cycle that shows the final drain beat
    busy_n = (st_n == CALC) || (ptr_n != '0) || drn_n
          || (drn && !clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= FILL;
      ptr        <= '0;
      drn        <= 1'b0;
      dcnt       <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_half   <= 1'b0;
      out_idx    <= '0;
      block_done <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      st         <= st_n;
      ptr        <= ptr_n;
      drn        <= drn_n;
      dcnt       <= dcnt_n;
      busy       <= busy_n;
      out_valid  <= 1'b0;
      out_half   <= 1'b0;
      out_idx    <= '0;
      block_done <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      // sums and drain are disjoint in time by construction
      if (acc && st == CALC) begin
        out_valid <= 1'b1;
        out_idx   <= ptr;
        out_re    <= sum_re;
        out_im    <= sum_im;
      end else if (drn && !clr) begin
        out_valid  <= 1'b1;
        out_half   <= 1'b1;
        out_idx    <= dcnt;
        out_re     <= mem_re[dcnt];
        out_im     <= mem_im[dcnt];
        block_done <= (dcnt == LAST);
      end
    end
  end

  // drain read above sees the old entry when FILL rewrites it
  always_ff @(posedge clk) begin
    if (acc) begin
      if (st == FILL) begin
        mem_re[ptr] <= ext_re;
        mem_im[ptr] <= ext_im;
      end else begin
        mem_re[ptr] <= dif_re;
        mem_im[ptr] <= dif_im;
      end
    end
  end

endmodule
